// File: rtl/cve2_pkg.sv
// rtl/cve2_pkg.sv - shared cve2 types: multdiv operators, issue FSM states, RV32M funct3 decode
package cve2_pkg;

  typedef enum logic [1:0] {
    MD_OP_MULL = 2'd0,
    MD_OP_MULH = 2'd1,
    MD_OP_DIV  = 2'd2,
    MD_OP_REM  = 2'd3
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE  = 2'd0,
    MD_BUSY  = 2'd1,
    MD_DRAIN = 2'd2
  } md_issue_state_e;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam int unsigned IMD_W = 34;

  typedef struct packed {
    md_op_e     op;
    logic [1:0] signed_mode;
  } md_decode_t;

  // signed_mode bit0 marks op_a as signed, bit1 marks op_b as signed
  function automatic md_decode_t md_decode(input logic [2:0] funct3);
    md_decode_t d;
    d.op          = MD_OP_MULL;
    d.signed_mode = 2'b00;
    case (funct3)
      F3_MUL:    begin d.op = MD_OP_MULL; d.signed_mode = 2'b00; end
      F3_MULH:   begin d.op = MD_OP_MULH; d.signed_mode = 2'b11; end
      F3_MULHSU: begin d.op = MD_OP_MULH; d.signed_mode = 2'b01; end
      F3_MULHU:  begin d.op = MD_OP_MULH; d.signed_mode = 2'b00; end
      F3_DIV:    begin d.op = MD_OP_DIV;  d.signed_mode = 2'b11; end
      F3_DIVU:   begin d.op = MD_OP_DIV;  d.signed_mode = 2'b00; end
      F3_REM:    begin d.op = MD_OP_REM;  d.signed_mode = 2'b11; end
      F3_REMU:   begin d.op = MD_OP_REM;  d.signed_mode = 2'b00; end
      default:   begin d.op = MD_OP_MULL; d.signed_mode = 2'b00; end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/cve2_multdiv_imd_regs.sv
// rtl/cve2_multdiv_imd_regs.sv - two 34-bit engine intermediate registers with per-word write enables
module cve2_multdiv_imd_regs
  import cve2_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [2*IMD_W-1:0]   imd_val_d_i,
  input  logic [1:0]           imd_val_we_i,
  output logic [2*IMD_W-1:0]   imd_val_q_o
);

  logic [2*IMD_W-1:0] imd_q;

  // Written independently of the issue FSM so the engine can iterate even while draining
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      imd_q <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (imd_val_we_i[k]) begin
          imd_q[k*IMD_W +: IMD_W] <= imd_val_d_i[k*IMD_W +: IMD_W];
        end
      end
    end
  end

  assign imd_val_q_o = imd_q;

endmodule

// File: rtl/cve2_multdiv_issue.sv
// rtl/cve2_multdiv_issue.sv - RV32M issue FSM: latches operands, drives the multdiv engine, returns writeback
module cve2_multdiv_issue
  import cve2_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [2:0]           req_funct3_i,
  input  logic [31:0]          req_op_a_i,
  input  logic [31:0]          req_op_b_i,
  input  logic [4:0]           req_rd_i,
  input  logic                 flush_i,
  output logic                 mult_en_o,
  output logic                 div_en_o,
  output logic                 mult_sel_o,
  output logic                 div_sel_o,
  output logic [1:0]           operator_o,
  output logic [1:0]           signed_mode_o,
  output logic [31:0]          op_a_o,
  output logic [31:0]          op_b_o,
  input  logic [2*IMD_W-1:0]   imd_val_d_i,
  input  logic [1:0]           imd_val_we_i,
  output logic [2*IMD_W-1:0]   imd_val_q_o,
  input  logic                 valid_i,
  input  logic [31:0]          result_i,
  output logic                 multdiv_ready_id_o,
  output logic                 wb_valid_o,
  input  logic                 wb_ready_i,
  output logic [4:0]           wb_rd_o,
  output logic [31:0]          wb_data_o,
  output logic                 busy_o
);

  md_issue_state_e state_q;
  md_op_e          operator_q;
  logic [1:0]      signed_mode_q;
  logic [31:0]     op_a_q;
  logic [31:0]     op_b_q;
  logic [4:0]      rd_q;
  logic            req_ready_q;
  logic            busy_q;
  logic            mult_q;
  logic            div_q;
  md_decode_t      dec;

  assign dec = md_decode(req_funct3_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= MD_IDLE;
      operator_q    <= MD_OP_MULL;
      signed_mode_q <= 2'b00;
      op_a_q        <= '0;
      op_b_q        <= '0;
      rd_q          <= '0;
      req_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
      mult_q        <= 1'b0;
      div_q         <= 1'b0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (req_valid_i && !flush_i) begin
            state_q       <= MD_BUSY;
            operator_q    <= dec.op;
            signed_mode_q <= dec.signed_mode;
            op_a_q        <= req_op_a_i;
            op_b_q        <= req_op_b_i;
            rd_q          <= req_rd_i;
            req_ready_q   <= 1'b0;
            busy_q        <= 1'b1;
            mult_q        <= (dec.op == MD_OP_MULL) || (dec.op == MD_OP_MULH);
            div_q         <= (dec.op == MD_OP_DIV) || (dec.op == MD_OP_REM);
          end
        end
        MD_BUSY: begin
          // Flushing without a result must keep the engine enabled until it finishes
          if (flush_i && !valid_i) begin
            state_q <= MD_DRAIN;
          end else if (valid_i && (flush_i || wb_ready_i)) begin
            state_q     <= MD_IDLE;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            mult_q      <= 1'b0;
            div_q       <= 1'b0;
          end
        end
        MD_DRAIN: begin
          if (valid_i) begin
            state_q     <= MD_IDLE;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            mult_q      <= 1'b0;
            div_q       <= 1'b0;
          end
        end
        default: begin
          state_q     <= MD_IDLE;
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          mult_q      <= 1'b0;
          div_q       <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o        = req_ready_q;
  assign busy_o             = busy_q;
  assign mult_en_o          = mult_q;
  assign mult_sel_o         = mult_q;
  assign div_en_o           = div_q;
  assign div_sel_o          = div_q;
  assign operator_o         = operator_q;
  assign signed_mode_o      = signed_mode_q;
  assign op_a_o             = op_a_q;
  assign op_b_o             = op_b_q;
  assign wb_rd_o            = rd_q;
  assign wb_data_o          = result_i;
  assign wb_valid_o         = (state_q == MD_BUSY) && valid_i && !flush_i;
  assign multdiv_ready_id_o = (state_q == MD_BUSY) ? wb_ready_i : (state_q == MD_DRAIN);

  cve2_multdiv_imd_regs u_imd_regs (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .imd_val_d_i  (imd_val_d_i),
    .imd_val_we_i (imd_val_we_i),
    .imd_val_q_o  (imd_val_q_o)
  );

endmodule

// File: tb/tb_cve2_multdiv_issue.sv
// tb/tb_cve2_multdiv_issue.sv - directed and random checks of the multdiv issue FSM against an RV32M model
module tb_cve2_multdiv_issue;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [2:0]  req_funct3_i;
    logic [31:0] req_op_a_i;
    logic [31:0] req_op_b_i;
    logic [4:0]  req_rd_i;
    logic        flush_i;
    logic        mult_en_o, div_en_o, mult_sel_o, div_sel_o;
    logic [1:0]  operator_o;
    logic [1:0]  signed_mode_o;
    logic [31:0] op_a_o, op_b_o;
    logic [67:0] imd_val_d_i;
    logic [1:0]  imd_val_we_i;
    logic [67:0] imd_val_q_o;
    logic        valid_i;
    logic [31:0] result_i;
    logic        multdiv_ready_id_o;
    logic        wb_valid_o;
    logic        wb_ready_i;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic        busy_o;

    int total = 0;
    int bad   = 0;

    int exp_op [8] = '{0, 1, 1, 1, 2, 2, 3, 3};
    int exp_sm [8] = '{0, 3, 1, 0, 3, 0, 3, 0};

    always #5 clk = ~clk;

    cve2_multdiv_issue dut (
        .clk_i              (clk),
        .rst_i              (rst_i),
        .req_valid_i        (req_valid_i),
        .req_ready_o        (req_ready_o),
        .req_funct3_i       (req_funct3_i),
        .req_op_a_i         (req_op_a_i),
        .req_op_b_i         (req_op_b_i),
        .req_rd_i           (req_rd_i),
        .flush_i            (flush_i),
        .mult_en_o          (mult_en_o),
        .div_en_o           (div_en_o),
        .mult_sel_o         (mult_sel_o),
        .div_sel_o          (div_sel_o),
        .operator_o         (operator_o),
        .signed_mode_o      (signed_mode_o),
        .op_a_o             (op_a_o),
        .op_b_o             (op_b_o),
        .imd_val_d_i        (imd_val_d_i),
        .imd_val_we_i       (imd_val_we_i),
        .imd_val_q_o        (imd_val_q_o),
        .valid_i            (valid_i),
        .result_i           (result_i),
        .multdiv_ready_id_o (multdiv_ready_id_o),
        .wb_valid_o         (wb_valid_o),
        .wb_ready_i         (wb_ready_i),
        .wb_rd_o            (wb_rd_o),
        .wb_data_o          (wb_data_o),
        .busy_o             (busy_o)
    );

    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, ub, ps;
        logic [63:0]        pu;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ub = {32'b0, b};
        pu = {32'b0, a} * {32'b0, b};
        case (f3)
            3'b000: return pu[31:0];
            3'b001: begin ps = sa * sb; return ps[63:32]; end
            3'b010: begin ps = sa * ub; return ps[63:32]; end
            3'b011: return pu[63:32];
            3'b100: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                return $signed(a) / $signed(b);
            end
            3'b101: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'b110: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                return $signed(a) % $signed(b);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic fail(input string tag, input logic [67:0] o, input logic [67:0] e);
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        req_valid_i = 1'b1; req_funct3_i = f3; req_op_a_i = a; req_op_b_i = b; req_rd_i = rd;
        #1;
        total++; if (68'(req_ready_o) !== 68'(1'b1)) fail("req_ready_idle", req_ready_o, 1'b1);
        step();
        req_valid_i = 1'b0; req_op_a_i = $urandom; req_op_b_i = $urandom; req_rd_i = 5'($urandom);
        req_funct3_i = 3'($urandom);
        #1;
        total++; if (68'(busy_o) !== 68'(1'b1)) fail("busy_after_accept", busy_o, 1'b1);
        total++; if (68'(req_ready_o) !== 68'(1'b0)) fail("req_ready_busy", req_ready_o, 1'b0);
        total++; if (68'(mult_en_o) !== 68'(exp_op[f3] < 2)) fail("mult_en", mult_en_o, exp_op[f3] < 2);
        total++; if (68'(mult_sel_o) !== 68'(exp_op[f3] < 2)) fail("mult_sel", mult_sel_o, exp_op[f3] < 2);
        total++; if (68'(div_en_o) !== 68'(exp_op[f3] >= 2)) fail("div_en", div_en_o, exp_op[f3] >= 2);
        total++; if (68'(div_sel_o) !== 68'(exp_op[f3] >= 2)) fail("div_sel", div_sel_o, exp_op[f3] >= 2);
        total++; if (68'(operator_o) !== 68'(exp_op[f3])) fail("operator", operator_o, exp_op[f3]);
        total++; if (68'(signed_mode_o) !== 68'(exp_sm[f3])) fail("signed_mode", signed_mode_o, exp_sm[f3]);
        total++; if (68'(op_a_o) !== 68'(a)) fail("op_a", op_a_o, a);
        total++; if (68'(op_b_o) !== 68'(b)) fail("op_b", op_b_o, b);
        total++; if (68'(wb_rd_o) !== 68'(rd)) fail("rd", wb_rd_o, rd);
    endtask

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int lat, input int stall);
        logic [31:0] r;
        r = ref_result(f3, a, b);
        accept(f3, a, b, rd);
        for (int i = 0; i < lat; i++) begin
            total++; if (68'(wb_valid_o) !== 68'(1'b0)) fail("wb_valid_wait", wb_valid_o, 1'b0);
            step();
        end
        valid_i = 1'b1; result_i = r; wb_ready_i = 1'b0;
        for (int i = 0; i < stall; i++) begin
            #1;
            total++; if (68'(wb_valid_o) !== 68'(1'b1)) fail("wb_valid_stall", wb_valid_o, 1'b1);
            total++; if (68'(multdiv_ready_id_o) !== 68'(1'b0)) fail("md_ready_stall", multdiv_ready_id_o, 1'b0);
            total++; if (68'(busy_o) !== 68'(1'b1)) fail("busy_stall", busy_o, 1'b1);
            step();
        end
        wb_ready_i = 1'b1;
        #1;
        total++; if (68'(wb_valid_o) !== 68'(1'b1)) fail("wb_valid", wb_valid_o, 1'b1);
        total++; if (68'(wb_data_o) !== 68'(r)) fail("wb_data", wb_data_o, r);
        total++; if (68'(wb_rd_o) !== 68'(rd)) fail("wb_rd", wb_rd_o, rd);
        total++; if (68'(op_a_o) !== 68'(a)) fail("op_a_held", op_a_o, a);
        total++; if (68'(multdiv_ready_id_o) !== 68'(1'b1)) fail("md_ready", multdiv_ready_id_o, 1'b1);
        step();
        valid_i = 1'b0; wb_ready_i = 1'b0; result_i = '0;
        #1;
        total++; if (68'(busy_o) !== 68'(1'b0)) fail("busy_done", busy_o, 1'b0);
        total++; if (68'(req_ready_o) !== 68'(1'b1)) fail("req_ready_done", req_ready_o, 1'b1);
        total++; if (68'(mult_en_o) !== 68'(1'b0)) fail("mult_en_done", mult_en_o, 1'b0);
        total++; if (68'(div_en_o) !== 68'(1'b0)) fail("div_en_done", div_en_o, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [67:0] d;
        logic [31:0] ra, rb;
        logic [2:0]  rf;
        rst_i = 1'b1; req_valid_i = 1'b0; req_funct3_i = '0; req_op_a_i = '0; req_op_b_i = '0;
        req_rd_i = '0; flush_i = 1'b0; imd_val_d_i = '0; imd_val_we_i = '0; valid_i = 1'b0;
        result_i = '0; wb_ready_i = 1'b0;
        step(); step();
        rst_i = 1'b0;
        #1;
        total++; if (68'(req_ready_o) !== 68'(1'b1)) fail("rst_req_ready", req_ready_o, 1'b1);
        total++; if (68'(busy_o) !== 68'(1'b0)) fail("rst_busy", busy_o, 1'b0);
        total++; if (68'(mult_en_o) !== 68'(1'b0)) fail("rst_mult_en", mult_en_o, 1'b0);
        total++; if (68'(div_en_o) !== 68'(1'b0)) fail("rst_div_en", div_en_o, 1'b0);
        total++; if (68'(op_a_o) !== 68'(0)) fail("rst_op_a", op_a_o, 0);
        total++; if (68'(imd_val_q_o) !== 68'(0)) fail("rst_imd", imd_val_q_o, 0);
        total++; if (68'(multdiv_ready_id_o) !== 68'(1'b0)) fail("rst_md_ready", multdiv_ready_id_o, 1'b0);
        total++; if (68'(wb_valid_o) !== 68'(1'b0)) fail("rst_wb_valid", wb_valid_o, 1'b0);

        run_op(3'b000, 32'd7, 32'hFFFFFFFD, 5'd9, 2, 0);
        run_op(3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd17, 4, 0);
        run_op(3'b001, 32'h12345678, 32'h9ABCDEF0, 5'd3, 1, 3);
        run_op(3'b110, 32'h0000000F, 32'h0, 5'd31, 0, 1);

        accept(3'b101, 32'd1000, 32'd7, 5'd12);
        repeat (5) step();
        flush_i = 1'b1;
        #1;
        total++; if (68'(wb_valid_o) !== 68'(1'b0)) fail("flush_no_wb", wb_valid_o, 1'b0);
        step();
        flush_i = 1'b0;
        #1;
        total++; if (68'(busy_o) !== 68'(1'b1)) fail("drain_busy", busy_o, 1'b1);
        total++; if (68'(div_en_o) !== 68'(1'b1)) fail("drain_div_en", div_en_o, 1'b1);
        total++; if (68'(multdiv_ready_id_o) !== 68'(1'b1)) fail("drain_md_ready", multdiv_ready_id_o, 1'b1);
        total++; if (68'(req_ready_o) !== 68'(1'b0)) fail("drain_req_ready", req_ready_o, 1'b0);
        step();
        valid_i = 1'b1; result_i = 32'd142; flush_i = 1'b1; wb_ready_i = 1'b1;
        #1;
        total++; if (68'(wb_valid_o) !== 68'(1'b0)) fail("drain_no_wb", wb_valid_o, 1'b0);
        total++; if (68'(div_en_o) !== 68'(1'b1)) fail("drain_div_en_valid", div_en_o, 1'b1);
        step();
        valid_i = 1'b0; flush_i = 1'b0; wb_ready_i = 1'b0; result_i = '0;
        #1;
        total++; if (68'(busy_o) !== 68'(1'b0)) fail("drain_exit_busy", busy_o, 1'b0);
        total++; if (68'(div_en_o) !== 68'(1'b0)) fail("drain_exit_div_en", div_en_o, 1'b0);
        run_op(3'b111, 32'd1000, 32'd7, 5'd13, 3, 0);

        accept(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4);
        valid_i = 1'b1; flush_i = 1'b1; wb_ready_i = 1'b1; result_i = 32'hFFFFFFFE;
        #1;
        total++; if (68'(wb_valid_o) !== 68'(1'b0)) fail("flush_valid_no_wb", wb_valid_o, 1'b0);
        step();
        valid_i = 1'b0; flush_i = 1'b0; wb_ready_i = 1'b0; result_i = '0;
        #1;
        total++; if (68'(busy_o) !== 68'(1'b0)) fail("flush_valid_idle", busy_o, 1'b0);

        req_valid_i = 1'b1; flush_i = 1'b1; req_funct3_i = 3'b000; req_op_a_i = 32'd5;
        step();
        req_valid_i = 1'b0; flush_i = 1'b0;
        #1;
        total++; if (68'(busy_o) !== 68'(1'b0)) fail("drop_busy", busy_o, 1'b0);
        total++; if (68'(mult_en_o) !== 68'(1'b0)) fail("drop_mult_en", mult_en_o, 1'b0);
        total++; if (68'(div_en_o) !== 68'(1'b0)) fail("drop_div_en", div_en_o, 1'b0);
        total++; if (68'(req_ready_o) !== 68'(1'b1)) fail("drop_req_ready", req_ready_o, 1'b1);

        d = {4'($urandom), $urandom, $urandom};
        imd_val_d_i = d; imd_val_we_i = 2'b01;
        step();
        imd_val_d_i = ~d; imd_val_we_i = 2'b10;
        step();
        imd_val_we_i = 2'b00;
        #1;
        total++; if (68'(imd_val_q_o) !== 68'({~d[67:34], d[33:0]})) fail("imd_words", imd_val_q_o, {~d[67:34], d[33:0]});

        for (int n = 0; n < 24; n++) begin
            rf = 3'($urandom);
            ra = $urandom;
            rb = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
            if ($urandom_range(0, 7) == 0) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
            run_op(rf, ra, rb, 5'($urandom), $urandom_range(0, 6), $urandom_range(0, 2));
        end

        accept(3'b100, 32'd99, 32'd3, 5'd21);
        d = {4'($urandom), $urandom, $urandom};
        imd_val_d_i = d; imd_val_we_i = 2'b11;
        step();
        #1;
        total++; if (68'(imd_val_q_o) !== 68'(d)) fail("imd_busy_write", imd_val_q_o, d);
        rst_i = 1'b1; valid_i = 1'b1; wb_ready_i = 1'b1; req_valid_i = 1'b1; result_i = '0;
        step();
        #1;
        total++; if (68'(busy_o) !== 68'(1'b0)) fail("rst_busy_idle", busy_o, 1'b0);
        total++; if (68'(req_ready_o) !== 68'(1'b1)) fail("rst_busy_req_ready", req_ready_o, 1'b1);
        total++; if (68'(imd_val_q_o) !== 68'(0)) fail("rst_busy_imd", imd_val_q_o, 0);
        total++; if (68'(wb_valid_o) !== 68'(1'b0)) fail("rst_busy_wb_valid", wb_valid_o, 1'b0);
        total++; if (68'(multdiv_ready_id_o) !== 68'(1'b0)) fail("rst_busy_md_ready", multdiv_ready_id_o, 1'b0);
        total++; if (68'(div_en_o) !== 68'(1'b0)) fail("rst_busy_div_en", div_en_o, 1'b0);
        total++; if (68'(operator_o) !== 68'(0)) fail("rst_busy_operator", operator_o, 0);
        total++; if (68'(signed_mode_o) !== 68'(0)) fail("rst_busy_signed", signed_mode_o, 0);
        total++; if (68'(op_b_o) !== 68'(0)) fail("rst_busy_op_b", op_b_o, 0);
        total++; if (68'(wb_rd_o) !== 68'(0)) fail("rst_busy_rd", wb_rd_o, 0);
        total++; if (68'(wb_data_o) !== 68'(0)) fail("rst_busy_wb_data", wb_data_o, 0);
        rst_i = 1'b0; valid_i = 1'b0; wb_ready_i = 1'b0; req_valid_i = 1'b0; imd_val_we_i = 2'b00;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cve2_multdiv_issue.md
CVE2_MULTDIV_ISSUE -- requirements
Module: cve2_multdiv_issue

Interface
REQ-001 SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 SHALL have ports, clock and reset first:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_valid_i  in  1  M-extension instruction offered
- req_ready_o  out  1  issue can accept a request
- req_funct3_i  in  3  RV32M funct3
- req_op_a_i  in  32  rs1 value
- req_op_b_i  in  32  rs2 value
- req_rd_i  in  5  destination register
- flush_i  in  1  kill any in-flight operation
- mult_en_o, div_en_o  out  1 each  engine enables
- mult_sel_o, div_sel_o  out  1 each  engine selects
- operator_o  out  2  0 MULL, 1 MULH, 2 DIV, 3 REM
- signed_mode_o  out  2  bit0 op_a signed, bit1 op_b signed
- op_a_o, op_b_o  out  32 each  latched operands
- imd_val_d_i  in  68  engine intermediate next values, two 34-bit words
- imd_val_we_i  in  2  per-word write enables
- imd_val_q_o  out  68  stored intermediate values
- valid_i  in  1  engine result valid
- result_i  in  32  engine result
- multdiv_ready_id_o  out  1  result consumed; engine may leave final state
- wb_valid_o  out  1  writeback data valid
- wb_ready_i  in  1  writeback accepts
- wb_rd_o  out  5  destination register
- wb_data_o  out  32  result
- busy_o  out  1  FSM not IDLE (pipeline stall)

Function
REQ-003 SHALL implement FSM states IDLE, BUSY, DRAIN.
REQ-004 SHALL assert req_ready_o only in IDLE.
REQ-005 SHALL, in IDLE with req_valid_i and no flush_i, latch funct3-decoded operator/signed_mode, op_a, op_b and rd, then enter BUSY next cycle.
REQ-006 SHALL decode funct3 as: 000 MULL/00; 001 MULH/11; 010 MULH/01; 011 MULH/00; 100 DIV/11; 101 DIV/00; 110 REM/11; 111 REM/00.
REQ-007 SHALL drive mult_en_o=mult_sel_o=1 for operators 0/1 and div_en_o=div_sel_o=1 for operators 2/3, only in BUSY and DRAIN; all four are 0 in IDLE.
REQ-008 SHALL hold operator_o, signed_mode_o, op_a_o, op_b_o and wb_rd_o stable from BUSY entry until return to IDLE.
REQ-009 SHALL drive wb_valid_o = BUSY & valid_i & ~flush_i, and wb_data_o = result_i combinationally.
REQ-010 SHALL drive multdiv_ready_id_o = wb_ready_i in BUSY, 1 in DRAIN, 0 in IDLE.
REQ-011 SHALL leave BUSY for IDLE when valid_i & wb_ready_i; the next request is accepted no earlier than that IDLE cycle.
REQ-012 SHALL, on flush_i in BUSY without valid_i, enter DRAIN; when valid_i is also present, go directly to IDLE with wb_valid_o suppressed.
REQ-013 SHALL, in DRAIN, keep enables asserted, suppress wb_valid_o, and return to IDLE on the cycle after valid_i, so the engine always reaches its idle state.
REQ-014 SHALL ignore flush_i in DRAIN, and SHALL drop a request in IDLE when flush_i is high in the same cycle.
REQ-015 SHALL update imd_val_q_o word k (bits 34k+33:34k) from imd_val_d_i on any clock edge with imd_val_we_i[k], regardless of FSM state.
REQ-016 SHALL drive busy_o = (state != IDLE).

Reset
REQ-017 SHALL, on rst_i, enter IDLE, clear all latched operands, rd, operator, signed_mode and imd_val_q_o to 0, and give every output 0 except req_ready_o=1.
REQ-018 SHALL let reset mid-operation override all inputs with no writeback; re-synchronising the engine is the system reset's responsibility.

Structure
REQ-019 SHALL take operator encodings, FSM state encodings and the funct3 decode constants from the shared cve2 package.
REQ-020 SHALL place the 2x34-bit intermediate register in a sub-module cve2_multdiv_imd_regs.

Verification
REQ-021 MUL 7 x -3 (funct3 000): req accepted, mult_en_o=1 next cycle, engine valid -> wb_data_o=0xFFFFFFEB, rd preserved, IDLE after handshake.
REQ-022 DIV 0x80000000 / 0xFFFFFFFF (funct3 100): operator_o=2, signed_mode_o=11; wb_data_o=0x80000000.
REQ-023 Result valid with wb_ready_i=0 for 3 cycles: wb_valid_o held, multdiv_ready_id_o=0, state BUSY; completes on the cycle wb_ready_i rises.
REQ-024 flush_i 5 cycles into a DIVU: DRAIN entered, div_en_o stays 1, no wb_valid_o, IDLE one cycle after valid_i, the following REMU returns the correct result.
REQ-025 req_valid_i and flush_i together in IDLE: no acceptance, enables remain 0.
REQ-026 rst_i asserted in BUSY: next cycle IDLE, imd_val_q_o=0, req_ready_o=1, all other outputs 0.
